// File: rtl/axilite_cfg_slave.sv
// AXI-Lite configuration responder for the FIR engine.
// Holds ap_ctrl, data_length and the tap coefficient bank.
module axilite_cfg_slave #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_NUM    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ap_start,
    input  logic                   ap_done_i,
    output logic [pDATA_WIDTH-1:0] data_length,
    input  logic [3:0]             tap_raddr,
    output logic [pDATA_WIDTH-1:0] tap_rdata
);
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);

    logic                   aw_full;
    logic                   w_full;
    logic [pADDR_WIDTH-1:0] aw_addr_q;
    logic [pDATA_WIDTH-1:0] w_data_q;
    logic [pDATA_WIDTH-1:0] tap [pTAP_NUM];
    logic                   ap_done;
    logic                   ap_idle;
    r_state_t               r_state;
    logic                   r_ctrl;
    logic [pDATA_WIDTH-1:0] rd_data;
    logic                   rd_ctrl;
    logic                   wr_commit;
    logic                   r_hs;

    assign awready   = !aw_full;
    assign wready    = !w_full;
    assign wr_commit = aw_full && w_full;
    assign r_hs      = rvalid && rready;

    // AW and W land in independent single-entry buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else if (wr_commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (awvalid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (wvalid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            data_length <= '0;
            for (int i = 0; i < pTAP_NUM; i++)
                tap[i] <= '0;
        end else begin
            ap_start <= 1'b0;
            if (wr_commit && ap_idle) begin
                if (aw_addr_q == ADDR_CTRL && w_data_q[0]) begin
                    ap_start <= 1'b1;
                    ap_idle  <= 1'b0;
                end
                if (aw_addr_q == ADDR_LEN)
                    data_length <= w_data_q;
                for (int i = 0; i < pTAP_NUM; i++)
                    if (aw_addr_q == pADDR_WIDTH'(64 + 4 * i))
                        tap[i] <= w_data_q;
            end
            if (r_hs && r_ctrl)
                ap_done <= 1'b0;
            // A completion in the clearing cycle must not be lost
            if (ap_done_i) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_ctrl = 1'b0;
        if (araddr == ADDR_CTRL) begin
            rd_data = pDATA_WIDTH'({ap_idle, ap_done, 1'b0});
            rd_ctrl = 1'b1;
        end
        if (araddr == ADDR_LEN)
            rd_data = data_length;
        for (int i = 0; i < pTAP_NUM; i++)
            if (araddr == pADDR_WIDTH'(64 + 4 * i))
                rd_data = tap[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            r_ctrl  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    rdata   <= rd_data;
                    r_ctrl  <= rd_ctrl;
                    rvalid  <= 1'b1;
                    arready <= 1'b0;
                    r_state <= R_DATA;
                end
                R_DATA: if (rready) begin
                    rvalid  <= 1'b0;
                    arready <= 1'b1;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        tap_rdata = '0;
        for (int i = 0; i < pTAP_NUM; i++)
            if (tap_raddr == 4'(i))
                tap_rdata = tap[i];
    end
endmodule

// File: tb/tb_axilite_cfg_slave.sv
// Bench for axilite_cfg_slave: register model plus
// a queue of expected read data popped on R handshakes.
module tb_axilite_cfg_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready;
    logic [11:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic        arvalid, arready;
    logic [11:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic        ap_start, ap_done_i;
    logic [31:0] data_length;
    logic [3:0]  tap_raddr;
    logic [31:0] tap_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    logic [31:0] m_len;
    logic [31:0] m_tap [11];
    logic        m_idle, m_done;

    axilite_cfg_slave dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready),
        .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready),
        .wdata(wdata),
        .arvalid(arvalid), .arready(arready),
        .araddr(araddr),
        .rvalid(rvalid), .rready(rready),
        .rdata(rdata),
        .ap_start(ap_start), .ap_done_i(ap_done_i),
        .data_length(data_length),
        .tap_raddr(tap_raddr), .tap_rdata(tap_rdata)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_len  = '0;
        m_idle = 1'b1;
        m_done = 1'b0;
        for (int i = 0; i < 11; i++)
            m_tap[i] = '0;
    endfunction

    function automatic logic [31:0] model_rd(
        input logic [11:0] a);
        if (a == 12'h000)
            return {29'd0, m_idle, m_done, 1'b0};
        if (a == 12'h010)
            return m_len;
        for (int i = 0; i < 11; i++)
            if (a == 12'h040 + 12'(4 * i))
                return m_tap[i];
        return 32'd0;
    endfunction

    function automatic void model_wr(
        input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h000) begin
            if (d[0] && m_idle)
                m_idle = 1'b0;
        end else if (m_idle) begin
            if (a == 12'h010)
                m_len = d;
            for (int i = 0; i < 11; i++)
                if (a == 12'h040 + 12'(4 * i))
                    m_tap[i] = d;
        end
    endfunction

    // Returns at the negedge following the AW/W handshake
    task automatic axi_write(
        input logic [11:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_timeout: addr %h not accepted", a);
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        model_wr(a, d);
    endtask

    task automatic axi_read(
        input logic [11:0] a, input int stall, input bit pulse);
        logic [31:0] e;
        int n;
        exp_q.push_back(model_rd(a));
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_latency: rvalid %b want 1", rvalid);
        end
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < stall; k++) begin
            n_cmp++;
            if (rvalid !== 1'b1 || arready !== 1'b0 ||
                rdata !== exp_q[0]) begin
                n_bad++;
                $display("FAIL rd_stall: rv %b ar %b data %h want %h",
                         rvalid, arready, rdata, exp_q[0]);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        if (pulse)
            ap_done_i = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata !== e) begin
            n_bad++;
            $display("FAIL rd_data @%h: got %h want %h", a, rdata, e);
        end
        @(negedge clk);
        rready    = 1'b0;
        ap_done_i = 1'b0;
        if (a == 12'h000)
            m_done = 1'b0;
        if (pulse) begin
            m_done = 1'b1;
            m_idle = 1'b1;
        end
        n_cmp++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_release: rv %b ar %b want 0 1",
                     rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({awready, wready, arready, rvalid, ap_start} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_hs: got %b want 11100",
                     {awready, wready, arready, rvalid, ap_start});
        end
        n_cmp++;
        if (rdata !== 32'd0 || data_length !== 32'd0 ||
            tap_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_regs: rd %h len %h tap %h want 0",
                     rdata, data_length, tap_rdata);
        end
    endtask

    task automatic test_read_stall();
        axi_read(12'h000, 5, 1'b0);
    endtask

    task automatic test_tap_write();
        logic [11:0] a_t [3] = '{12'h040, 12'h044, 12'h068};
        logic [31:0] d_t [3] = '{32'h5, 32'h7, 32'h1234};
        logic [3:0]  i_t [3] = '{4'd0, 4'd1, 4'd10};
        logic [31:0] old;
        for (int k = 0; k < 3; k++) begin
            tap_raddr = i_t[k];
            old = m_tap[i_t[k]];
            axi_write(a_t[k], d_t[k]);
            n_cmp++;
            if (tap_rdata !== old || wready !== 1'b0) begin
                n_bad++;
                $display("FAIL tap_pending: tap %h wr %b want %h 0",
                         tap_rdata, wready, old);
            end
            @(negedge clk);
            n_cmp++;
            if (tap_rdata !== d_t[k] || !awready || !wready) begin
                n_bad++;
                $display("FAIL tap_commit: tap %h want %h rdy %b%b",
                         tap_rdata, d_t[k], awready, wready);
            end
        end
        tap_raddr = 4'd11;
        #1;
        n_cmp++;
        if (tap_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL tap_oob11: got %h want 0", tap_rdata);
        end
        tap_raddr = 4'd15;
        #1;
        n_cmp++;
        if (tap_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL tap_oob15: got %h want 0", tap_rdata);
        end
        tap_raddr = 4'd0;
        axi_read(12'h040, 0, 1'b0);
        axi_read(12'h044, 0, 1'b0);
    endtask

    task automatic test_w_first();
        @(negedge clk);
        wdata  = 32'd64;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wready !== 1'b0) begin
                n_bad++;
                $display("FAIL w_wait%0d: wready %b want 0", k, wready);
            end
            if (k < 2)
                @(negedge clk);
        end
        awaddr  = 12'h010;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        n_cmp++;
        if (data_length !== m_len) begin
            n_bad++;
            $display("FAIL len_early: got %h want %h", data_length, m_len);
        end
        @(negedge clk);
        model_wr(12'h010, 32'd64);
        n_cmp++;
        if (data_length !== 32'd64 || wready !== 1'b1) begin
            n_bad++;
            $display("FAIL len_commit: got %h wr %b want 40 1",
                     data_length, wready);
        end
        axi_read(12'h010, 0, 1'b0);
    endtask

    task automatic test_ap_ctrl();
        axi_write(12'h000, 32'h1);
        n_cmp++;
        if (ap_start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_early: got %b want 0", ap_start);
        end
        @(negedge clk);
        n_cmp++;
        if (ap_start !== 1'b1) begin
            n_bad++;
            $display("FAIL start_pulse: got %b want 1", ap_start);
        end
        @(negedge clk);
        n_cmp++;
        if (ap_start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_width: got %b want 0", ap_start);
        end
        axi_read(12'h000, 0, 1'b0);
        axi_write(12'h040, 32'h99);
        axi_write(12'h000, 32'h1);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (ap_start !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_start: got %b want 0", ap_start);
            end
        end
        n_cmp++;
        if (tap_rdata !== m_tap[0]) begin
            n_bad++;
            $display("FAIL busy_tap: got %h want %h", tap_rdata, m_tap[0]);
        end
        ap_done_i = 1'b1;
        @(negedge clk);
        ap_done_i = 1'b0;
        m_done = 1'b1;
        m_idle = 1'b1;
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
    endtask

    task automatic test_done_coincident();
        axi_write(12'h000, 32'h1);
        @(negedge clk);
        axi_read(12'h000, 0, 1'b1);
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
    endtask

    task automatic test_unmapped();
        axi_read(12'h7fc, 0, 1'b0);
        axi_write(12'h7fc, 32'hdeadbeef);
        axi_write(12'h042, 32'hcafef00d);
        @(negedge clk);
        n_cmp++;
        if (data_length !== m_len) begin
            n_bad++;
            $display("FAIL unmapped_len: got %h want %h",
                     data_length, m_len);
        end
        axi_read(12'h040, 0, 1'b0);
        axi_read(12'h044, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++)
            axi_write(12'h040 + 12'(4 * i), $urandom);
        axi_write(12'h010, $urandom);
        for (int i = 0; i < 11; i++)
            axi_read(12'h040 + 12'(4 * i), 0, 1'b0);
        axi_read(12'h010, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        awaddr  = 12'h010;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        araddr  = 12'h040;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || awready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_pending: rv %b awr %b want 1 0",
                     rvalid, awready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({rvalid, awready, wready, arready} !== 4'b0111 ||
            data_length !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset: flags %b len %h want 0111 0",
                     {rvalid, awready, wready, arready}, data_length);
        end
        wdata  = 32'h55;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_length !== 32'd0) begin
            n_bad++;
            $display("FAIL stale_aw: len %h want 0", data_length);
        end
        awaddr  = 12'h010;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        model_wr(12'h010, 32'h55);
        n_cmp++;
        if (data_length !== 32'h55) begin
            n_bad++;
            $display("FAIL post_reset_wr: len %h want 55", data_length);
        end
    endtask

    initial begin
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ap_done_i = 1'b0;
        awaddr    = '0;
        araddr    = '0;
        wdata     = '0;
        tap_raddr = '0;
        model_reset();
        test_reset();
        test_read_stall();
        test_tap_write();
        test_w_first();
        test_ap_ctrl();
        test_done_coincident();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule
